// File: rtl/debouncer.sv
// Per-bit key debouncer: two-flop synchroniser followed by a per-channel
// stability counter. The output adopts a new level only after that level
// has been seen on the synchronised input for STABLE_COUNT consecutive clocks.
module debouncer #(
  parameter int unsigned WIDTH        = 4,
  parameter int unsigned STABLE_COUNT = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] key_in,
  output logic [WIDTH-1:0] key_out
);

  localparam int unsigned CNT_W = $clog2(STABLE_COUNT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_COUNT - 1);

  logic [WIDTH-1:0] s1;
  logic [WIDTH-1:0] s2;
  logic [CNT_W-1:0] cnt [WIDTH];

  // Two-stage synchroniser for the asynchronous key levels.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= key_in;
      s2 <= s1;
    end
  end

  // Per-channel stability counter; any return to the current output level restarts it.
  always_ff @(posedge clk) begin
    if (reset) begin
      key_out <= '0;
      for (int i = 0; i < int'(WIDTH); i++) begin
        cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < int'(WIDTH); i++) begin
        if (s2[i] == key_out[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          key_out[i] <= s2[i];
          cnt[i]     <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_debouncer.sv
// Directed bench for debouncer with default parameters (WIDTH=4, STABLE_COUNT=3).
// A level applied before edge E0 and held appears on key_out after the 5th edge.
module tb_debouncer;

  logic       clk;
  logic       reset;
  logic [3:0] key_in;
  logic [3:0] key_out;

  int n_checks;
  int n_errors;

  debouncer #(.WIDTH(4), .STABLE_COUNT(3)) dut (
    .clk    (clk),
    .reset  (reset),
    .key_in (key_in),
    .key_out(key_out)
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: key_out=%b expected=%b at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Apply kin and hold it n edges: key_out must equal exp_hold after edges 1..n-1
  // and exp_end after edge n.
  task automatic hold(input string tag, input logic [3:0] kin, input int n,
                      input logic [3:0] exp_hold, input logic [3:0] exp_end);
    key_in = kin;
    for (int k = 1; k <= n; k++) begin
      tick();
      if (k < n) check($sformatf("%s_e%0d", tag, k), key_out, exp_hold);
      else       check($sformatf("%s_e%0d", tag, k), key_out, exp_end);
    end
  endtask

  logic [7:0] glitch_in;
  logic [7:0] glitch_exp;

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset    = 1'b1;
    key_in   = 4'b0001;

    // Reset hold: key_in ignored while reset is high.
    tick();
    check("reset_e1", key_out, 4'b0000);
    tick();
    check("reset_e2", key_out, 4'b0000);

    // Single press: 0 for edges 1..4, 0001 on edge 5.
    reset = 1'b0;
    hold("press", 4'b0001, 5, 4'b0000, 4'b0001);

    // Walking keys: old bit falls and new bit rises on the same edge.
    hold("walk1", 4'b0010, 5, 4'b0001, 4'b0010);
    hold("walk2", 4'b0100, 5, 4'b0010, 4'b0100);
    hold("walk3", 4'b1000, 5, 4'b0100, 4'b1000);

    // Release to get key_out back to zero.
    hold("rel0", 4'b0000, 5, 4'b1000, 4'b0000);

    // Glitch rejection: H H L then H held; only the final run of >=3 counts.
    // Input before edge i is glitch_in[i]; it is evaluated at edge i+2.
    // Runs seen by the counter: edges 2,3 high (cnt 1,2), edge 4 low (cnt 0),
    // edges 5,6,7 high -> key_out rises on edge 7 (index 7).
    glitch_in  = 8'b1111_1011;
    glitch_exp = 8'b1000_0000;
    for (int i = 0; i < 8; i++) begin
      key_in = {3'b000, glitch_in[i]};
      tick();
      check($sformatf("glitch_e%0d", i), key_out, {3'b000, glitch_exp[i]});
    end

    // Move to 1000 (bit0 falls, bit3 rises together).
    hold("to1000", 4'b1000, 5, 4'b0001, 4'b1000);

    // One-cycle low blip while pressed is rejected.
    hold("blip_lo", 4'b0000, 1, 4'b1000, 4'b1000);
    hold("blip_hi", 4'b1000, 5, 4'b1000, 4'b1000);

    // Release from 1000.
    hold("release", 4'b0000, 5, 4'b1000, 4'b0000);

    // Reset mid-count discards the pending press.
    hold("midcnt", 4'b0100, 3, 4'b0000, 4'b0000);
    reset = 1'b1;
    tick();
    check("midcnt_rst", key_out, 4'b0000);
    reset = 1'b0;
    hold("after_rst", 4'b0100, 5, 4'b0000, 4'b0100);

    // Two simultaneous changes time out together, independently.
    hold("dual", 4'b1001, 5, 4'b0100, 4'b1001);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
